// File: rtl/mac_forwarding_table_if.sv
// Request/response, maintenance and status signals between the orchestrator and the MAC table.
interface mac_forwarding_table_if #(
   parameter int unsigned NUMBER_OF_PORTS = 4,
   parameter int unsigned TABLE_ENTRIES   = 16
);
   localparam int unsigned PW = $clog2(NUMBER_OF_PORTS);
   localparam int unsigned CW = $clog2(TABLE_ENTRIES + 1);

   logic                       request_valid;
   logic                       request_ready;
   logic [47:0]                request_source_address;
   logic [47:0]                request_destination_address;
   logic [PW-1:0]              request_port;
   logic                       response_valid;
   logic [NUMBER_OF_PORTS-1:0] response_port_mask;
   logic                       response_hit;
   logic                       age_tick;
   logic                       flush;
   logic [CW-1:0]              entry_count;

   modport master (
      output request_valid, request_source_address, request_destination_address, request_port,
      output age_tick, flush,
      input  request_ready, response_valid, response_port_mask, response_hit, entry_count
   );

   modport slave (
      input  request_valid, request_source_address, request_destination_address, request_port,
      input  age_tick, flush,
      output request_ready, response_valid, response_port_mask, response_hit, entry_count
   );
endinterface

// File: rtl/mac_forwarding_table.sv
// MAC learning/forwarding table: sequential scans for search and aging, round-robin eviction,
// flood on miss/multicast and filter on same-port hits.
module mac_forwarding_table #(
   parameter int unsigned NUMBER_OF_PORTS = 4,
   parameter int unsigned TABLE_ENTRIES   = 16,
   parameter int unsigned AGE_LIMIT       = 300
) (
   input logic                   clock,
   input logic                   reset,
   mac_forwarding_table_if.slave bus
);
   localparam int unsigned PW = $clog2(NUMBER_OF_PORTS);
   localparam int unsigned IW = $clog2(TABLE_ENTRIES);
   localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
   localparam int unsigned CW = $clog2(TABLE_ENTRIES + 1);

   localparam logic [IW-1:0] LastIdx = IW'(TABLE_ENTRIES - 1);
   localparam logic [IW-1:0] IdxOne  = IW'(1);
   localparam logic [AW-1:0] AgeMax  = AW'(AGE_LIMIT);
   localparam logic [AW-1:0] AgeOne  = AW'(1);
   localparam logic [CW-1:0] CntOne  = CW'(1);
   localparam logic [NUMBER_OF_PORTS-1:0] PortBit0 = {{(NUMBER_OF_PORTS - 1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {StIdle, StFlush, StAge, StSearch, StUpdate, StRespond} state_e;

   state_e r_state, w_state_next;

   logic [TABLE_ENTRIES-1:0] r_valid;
   logic [47:0]              r_mac  [TABLE_ENTRIES];
   logic [PW-1:0]            r_port [TABLE_ENTRIES];
   logic [AW-1:0]            r_age  [TABLE_ENTRIES];
   logic [IW-1:0]            r_repl_ptr;
   logic [IW-1:0]            r_idx;
   logic [CW-1:0]            r_count;
   logic                     r_flush_pending;
   logic                     r_age_pending;

   logic [47:0]   r_sa;
   logic [47:0]   r_da;
   logic [PW-1:0] r_req_port;
   logic          r_dst_hit;
   logic [PW-1:0] r_dst_port;
   logic          r_src_hit;
   logic [IW-1:0] r_src_idx;
   logic          r_free_found;
   logic [IW-1:0] r_free_idx;

   logic [NUMBER_OF_PORTS-1:0] r_resp_mask;
   logic                       r_resp_hit;

   logic                       w_flush_req;
   logic                       w_age_req;
   logic                       w_accept;
   logic                       w_last;
   logic                       w_port_ok;
   logic                       w_learn;
   logic [AW-1:0]              w_age_inc;
   logic [NUMBER_OF_PORTS-1:0] w_ingress_bit;
   logic [NUMBER_OF_PORTS-1:0] w_dst_bit;

   // A pulse arriving this cycle counts as pending, so it beats a simultaneous request.
   assign w_flush_req   = r_flush_pending | bus.flush;
   assign w_age_req     = r_age_pending | bus.age_tick;
   assign w_accept      = bus.request_valid && bus.request_ready;
   assign w_last        = (r_idx == LastIdx);
   assign w_port_ok     = (32'(r_req_port) < NUMBER_OF_PORTS);
   assign w_learn       = !r_sa[40] && w_port_ok;
   assign w_age_inc     = r_age[r_idx] + AgeOne;
   assign w_ingress_bit = PortBit0 << r_req_port;
   assign w_dst_bit     = PortBit0 << r_dst_port;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (w_flush_req)    w_state_next = StFlush;
            else if (w_age_req) w_state_next = StAge;
            else if (w_accept)  w_state_next = StSearch;
         end
         StFlush:   w_state_next = StIdle;
         StAge:     if (w_last) w_state_next = StIdle;
         StSearch:  if (w_last) w_state_next = StUpdate;
         StUpdate:  w_state_next = StRespond;
         StRespond: w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
   end

   always_comb begin
      bus.request_ready      = (r_state == StIdle) && !w_flush_req && !w_age_req && !reset;
      bus.response_valid     = (r_state == StRespond);
      bus.response_port_mask = r_resp_mask;
      bus.response_hit       = r_resp_hit;
      bus.entry_count        = r_count;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid         <= '0;
         r_count         <= '0;
         r_repl_ptr      <= '0;
         r_idx           <= '0;
         r_flush_pending <= 1'b0;
         r_age_pending   <= 1'b0;
         r_resp_mask     <= '0;
         r_resp_hit      <= 1'b0;
      end else begin
         r_flush_pending <= bus.flush | (r_flush_pending & (r_state != StFlush));
         // Entering AGE clears the latch; a tick landing on that same edge is dropped.
         if (r_state == StIdle && !w_flush_req && w_age_req) begin
            r_age_pending <= 1'b0;
         end else if (bus.age_tick) begin
            r_age_pending <= 1'b1;
         end

         case (r_state)
            StIdle: begin
               r_idx <= '0;
               if (w_accept) begin
                  r_sa         <= bus.request_source_address;
                  r_da         <= bus.request_destination_address;
                  r_req_port   <= bus.request_port;
                  r_dst_hit    <= 1'b0;
                  r_src_hit    <= 1'b0;
                  r_free_found <= 1'b0;
               end
            end
            StFlush: begin
               r_valid    <= '0;
               r_count    <= '0;
               r_repl_ptr <= '0;
            end
            StAge: begin
               if (r_valid[r_idx]) begin
                  r_age[r_idx] <= w_age_inc;
                  if (w_age_inc == AgeMax) begin
                     r_valid[r_idx] <= 1'b0;
                     r_count        <= r_count - CntOne;
                  end
               end
               r_idx <= w_last ? '0 : r_idx + IdxOne;
            end
            StSearch: begin
               if (r_valid[r_idx]) begin
                  if (!r_dst_hit && r_mac[r_idx] == r_da) begin
                     r_dst_hit  <= 1'b1;
                     r_dst_port <= r_port[r_idx];
                  end
                  if (!r_src_hit && r_mac[r_idx] == r_sa) begin
                     r_src_hit <= 1'b1;
                     r_src_idx <= r_idx;
                  end
               end else if (!r_free_found) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_idx;
               end
               r_idx <= w_last ? '0 : r_idx + IdxOne;
            end
            StUpdate: begin
               if (w_learn) begin
                  if (r_src_hit) begin
                     r_port[r_src_idx] <= r_req_port;
                     r_age[r_src_idx]  <= '0;
                  end else if (r_free_found) begin
                     r_mac[r_free_idx]   <= r_sa;
                     r_port[r_free_idx]  <= r_req_port;
                     r_age[r_free_idx]   <= '0;
                     r_valid[r_free_idx] <= 1'b1;
                     r_count             <= r_count + CntOne;
                  end else begin
                     r_mac[r_repl_ptr]  <= r_sa;
                     r_port[r_repl_ptr] <= r_req_port;
                     r_age[r_repl_ptr]  <= '0;
                     r_repl_ptr <= (r_repl_ptr == LastIdx) ? '0 : r_repl_ptr + IdxOne;
                  end
               end
               // Search results predate this update, so the lookup never sees its own learn.
               if (!w_port_ok) begin
                  r_resp_mask <= '0;
                  r_resp_hit  <= 1'b0;
               end else if (r_da[40] || !r_dst_hit) begin
                  r_resp_mask <= ~w_ingress_bit;
                  r_resp_hit  <= 1'b0;
               end else if (r_dst_port == r_req_port) begin
                  r_resp_mask <= '0;
                  r_resp_hit  <= 1'b1;
               end else begin
                  r_resp_mask <= w_dst_bit;
                  r_resp_hit  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
